// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared constants for the decode / operand-fetch stage: MIPS-style opcode
// and funct encodings, the link register index, default widths and a small
// helper that classifies immediate extension.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    // Default widths: 32-bit datapath, 32 architectural registers.
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct for jump-register: reads rs, writes nothing.
    localparam logic [5:0] FN_JR    = 6'h08;

    // jal links into $ra.
    localparam logic [4:0] REG_RA   = 5'd31;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zext_op(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    endfunction

endpackage

// File: rtl/id_ex_stage_decode.sv
// ---------------------------------------------------------------------------
// id_decode
// Purely combinational instruction decoder for the ID stage.
//
// Ports:
//   opcode_i   instr[31:26]
//   rt_i       instr[20:16]
//   rd_i       instr[15:11]
//   funct_i    instr[5:0]
//   imm16_i    instr[15:0]
//   dest_o     destination register index
//   wr_en_o    instruction writes dest_o (never set when dest_o == 0)
//   is_load_o  instruction is lw
//   uses_rt_o  instruction reads rt as a source operand
//   imm_o      zero- or sign-extended immediate
// ---------------------------------------------------------------------------
module id_decode
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [5:0]        opcode_i,
    input  logic [ADDR_W-1:0] rt_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm16_i,
    output logic [ADDR_W-1:0] dest_o,
    output logic              wr_en_o,
    output logic              is_load_o,
    output logic              uses_rt_o,
    output logic [DATA_W-1:0] imm_o
);

    logic wr_raw;

    always_comb begin
        dest_o    = '0;
        wr_raw    = 1'b0;
        uses_rt_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                dest_o    = rd_i;
                wr_raw    = (funct_i != FN_JR);
                uses_rt_o = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                dest_o = rt_i;
                wr_raw = 1'b1;
            end
            OP_JAL: begin
                dest_o = ADDR_W'(REG_RA);
                wr_raw = 1'b1;
            end
            // Branches and stores compare/store rt but write nothing.
            OP_BEQ, OP_BNE, OP_SW: begin
                uses_rt_o = 1'b1;
            end
            default: ;
        endcase
        // Writes to $zero are architecturally discarded; dropping them here
        // also keeps them out of the load-use comparison downstream.
        wr_en_o = wr_raw && (dest_o != '0);
    end

    assign is_load_o = (opcode_i == OP_LW);

    assign imm_o = is_zext_op(opcode_i) ? {{(DATA_W-16){1'b0}}, imm16_i}
                                        : {{(DATA_W-16){imm16_i[15]}}, imm16_i};

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode and operand-fetch stage feeding the ID/EX pipeline register.
// Drives the register-file read addresses from the fetched instruction,
// applies the same-edge write-back bypass, detects load-use hazards and
// inserts one bubble for them, and honours flush and execute backpressure.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid && ready are both high. if_ready does not depend on if_valid.
// ex_valid only drops through a bubble, a flush or reset; while ex_valid
// is high and ex_ready low, every ex_* output is held stable.
//
// Ports:
//   clk, nrst                 clock, synchronous active-low reset
//   if_valid/if_ready         fetch-side handshake
//   if_instr, if_pc           instruction word and its address
//   rf_rd_addrA/B             register-file read addresses (rs, rt)
//   rf_rd_dataA/B             register-file read data (same cycle)
//   wb_wr_en/addr/data        write-back port writing the file this edge
//   flush                     kill the ID instruction and ID/EX contents
//   ex_ready/ex_valid         execute-side handshake
//   ex_pc, ex_opA, ex_opB,
//   ex_imm, ex_opcode,
//   ex_funct, ex_dest,
//   ex_wr_en, ex_is_load      ID/EX register contents
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic [ADDR_W-1:0] rf_rd_addrA,
    output logic [ADDR_W-1:0] rf_rd_addrB,
    input  logic [DATA_W-1:0] rf_rd_dataA,
    input  logic [DATA_W-1:0] rf_rd_dataB,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [ADDR_W-1:0] ex_dest,
    output logic              ex_wr_en,
    output logic              ex_is_load
);

    // Instruction fields.
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [5:0]        funct;
    logic [15:0]       imm16;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign funct  = if_instr[5:0];
    assign imm16  = if_instr[15:0];

    assign rf_rd_addrA = rs;
    assign rf_rd_addrB = rt;

    // Decoded control.
    logic [ADDR_W-1:0] dec_dest;
    logic              dec_wr_en;
    logic              dec_is_load;
    logic              dec_uses_rt;
    logic [DATA_W-1:0] dec_imm;

    id_decode #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .opcode_i  (opcode),
        .rt_i      (rt),
        .rd_i      (rd),
        .funct_i   (funct),
        .imm16_i   (imm16),
        .dest_o    (dec_dest),
        .wr_en_o   (dec_wr_en),
        .is_load_o (dec_is_load),
        .uses_rt_o (dec_uses_rt),
        .imm_o     (dec_imm)
    );

    // ID/EX pipeline register.
    logic              ex_valid_q,   ex_valid_d;
    logic [DATA_W-1:0] ex_pc_q,      ex_pc_d;
    logic [DATA_W-1:0] ex_opA_q,     ex_opA_d;
    logic [DATA_W-1:0] ex_opB_q,     ex_opB_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [5:0]        ex_opcode_q,  ex_opcode_d;
    logic [5:0]        ex_funct_q,   ex_funct_d;
    logic [ADDR_W-1:0] ex_dest_q,    ex_dest_d;
    logic              ex_wr_en_q,   ex_wr_en_d;
    logic              ex_is_load_q, ex_is_load_d;

    // The register file is written at the same edge we capture operands,
    // so its read port still returns the old value; forward write-back data.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (addr == '0)
            return '0;
        else if (wen && (waddr == addr))
            return wdata;
        else
            return rf_data;
    endfunction

    logic advance;
    logic hazard;
    logic accept;

    assign advance = !ex_valid_q || ex_ready;

    // A load in EX cannot deliver its data in time for a dependent
    // instruction in ID; holding ID for one cycle lets the bubble move the
    // load on, which clears the condition on the following cycle.
    assign hazard = ex_valid_q && ex_is_load_q && ex_wr_en_q &&
                    ((ex_dest_q == rs) || (dec_uses_rt && (ex_dest_q == rt)));

    assign if_ready = advance && !hazard && !flush;
    assign accept   = if_ready && if_valid;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_opA_d     = ex_opA_q;
        ex_opB_d     = ex_opB_q;
        ex_imm_d     = ex_imm_q;
        ex_opcode_d  = ex_opcode_q;
        ex_funct_d   = ex_funct_q;
        ex_dest_d    = ex_dest_q;
        ex_wr_en_d   = ex_wr_en_q;
        ex_is_load_d = ex_is_load_q;
        if (advance) begin
            // Either a fresh instruction or a bubble; bubble fields hold.
            ex_valid_d = accept;
            if (accept) begin
                ex_pc_d      = if_pc;
                ex_opA_d     = pick_operand(rs, rf_rd_dataA, wb_wr_en, wb_wr_addr, wb_wr_data);
                ex_opB_d     = pick_operand(rt, rf_rd_dataB, wb_wr_en, wb_wr_addr, wb_wr_data);
                ex_imm_d     = dec_imm;
                ex_opcode_d  = opcode;
                ex_funct_d   = funct;
                ex_dest_d    = dec_dest;
                ex_wr_en_d   = dec_wr_en;
                ex_is_load_d = dec_is_load;
            end
        end else if (flush) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_opA_q     <= '0;
            ex_opB_q     <= '0;
            ex_imm_q     <= '0;
            ex_opcode_q  <= '0;
            ex_funct_q   <= '0;
            ex_dest_q    <= '0;
            ex_wr_en_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_opA_q     <= ex_opA_d;
            ex_opB_q     <= ex_opB_d;
            ex_imm_q     <= ex_imm_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct_q   <= ex_funct_d;
            ex_dest_q    <= ex_dest_d;
            ex_wr_en_q   <= ex_wr_en_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_opA     = ex_opA_q;
    assign ex_opB     = ex_opB_q;
    assign ex_imm     = ex_imm_q;
    assign ex_opcode  = ex_opcode_q;
    assign ex_funct   = ex_funct_q;
    assign ex_dest    = ex_dest_q;
    assign ex_wr_en   = ex_wr_en_q;
    assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed cases with literal expectations, then randomized traffic checked
// every cycle against a transaction-level model of the ID/EX register.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_rd_addrA, rf_rd_addrB;
    logic [31:0] rf_rd_dataA, rf_rd_dataB;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_wr_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_opA, ex_opB, ex_imm;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_dest;
    logic        ex_wr_en, ex_is_load;

    id_ex_stage dut (
        .clk         (clk),
        .nrst        (nrst),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .rf_rd_addrA (rf_rd_addrA),
        .rf_rd_addrB (rf_rd_addrB),
        .rf_rd_dataA (rf_rd_dataA),
        .rf_rd_dataB (rf_rd_dataB),
        .wb_wr_en    (wb_wr_en),
        .wb_wr_addr  (wb_wr_addr),
        .wb_wr_data  (wb_wr_data),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_opA      (ex_opA),
        .ex_opB      (ex_opB),
        .ex_imm      (ex_imm),
        .ex_opcode   (ex_opcode),
        .ex_funct    (ex_funct),
        .ex_dest     (ex_dest),
        .ex_wr_en    (ex_wr_en),
        .ex_is_load  (ex_is_load)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        known = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc, m_opA, m_opB, m_imm;
    logic [5:0]  m_opcode, m_funct;
    logic [4:0]  m_dest;
    logic        m_wr, m_ld;

    function automatic logic [4:0] f_dest(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'd0)                          return ins[15:11];
        if (op inside {[6'd8:6'd15], 6'd35})     return ins[20:16];
        if (op == 6'd3)                          return 5'd31;
        return 5'd0;
    endfunction

    function automatic logic f_wr(input logic [31:0] ins);
        logic [5:0] op;
        logic       w;
        op = ins[31:26];
        w  = (op == 6'd0) ? (ins[5:0] != 6'd8)
                          : (op inside {[6'd8:6'd15], 6'd35, 6'd3});
        return w && (f_dest(ins) != 5'd0);
    endfunction

    function automatic logic f_uses_rt(input logic [31:0] ins);
        return ins[31:26] inside {6'd0, 6'd4, 6'd5, 6'd43};
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] ins);
        if (ins[31:26] inside {6'd12, 6'd13, 6'd14})
            return {16'h0000, ins[15:0]};
        return {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic logic [31:0] f_operand(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0)                       return 32'd0;
        if (wb_wr_en && wb_wr_addr == r)     return wb_wr_data;
        return rf;
    endfunction

    function automatic logic f_hazard();
        logic [4:0] s, t;
        s = if_instr[25:21];
        t = if_instr[20:16];
        return m_valid && m_ld && m_wr &&
               (m_dest == s || (m_dest == t && f_uses_rt(if_instr)));
    endfunction

    function automatic logic f_advance();
        return !m_valid || ex_ready;
    endfunction

    always @(posedge clk) begin
        if (!nrst) begin
            known    <= 1'b1;
            m_valid  <= 1'b0;
            m_pc     <= '0;
            m_opA    <= '0;
            m_opB    <= '0;
            m_imm    <= '0;
            m_opcode <= '0;
            m_funct  <= '0;
            m_dest   <= '0;
            m_wr     <= 1'b0;
            m_ld     <= 1'b0;
        end else if (known) begin
            if (f_advance()) begin
                if (flush || f_hazard() || !if_valid) begin
                    m_valid <= 1'b0;
                end else begin
                    m_valid  <= 1'b1;
                    m_pc     <= if_pc;
                    m_opA    <= f_operand(if_instr[25:21], rf_rd_dataA);
                    m_opB    <= f_operand(if_instr[20:16], rf_rd_dataB);
                    m_imm    <= f_imm(if_instr);
                    m_opcode <= if_instr[31:26];
                    m_funct  <= if_instr[5:0];
                    m_dest   <= f_dest(if_instr);
                    m_wr     <= f_wr(if_instr);
                    m_ld     <= (if_instr[31:26] == 6'd35);
                end
            end else if (flush) begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (known) begin
            check("m_if_ready", {31'd0, if_ready}, {31'd0, f_advance() && !f_hazard() && !flush});
            check("m_addrA",    {27'd0, rf_rd_addrA}, {27'd0, if_instr[25:21]});
            check("m_addrB",    {27'd0, rf_rd_addrB}, {27'd0, if_instr[20:16]});
            check("m_valid",    {31'd0, ex_valid}, {31'd0, m_valid});
            check("m_pc",       ex_pc,  m_pc);
            check("m_opA",      ex_opA, m_opA);
            check("m_opB",      ex_opB, m_opB);
            check("m_imm",      ex_imm, m_imm);
            check("m_opcode",   {26'd0, ex_opcode}, {26'd0, m_opcode});
            check("m_funct",    {26'd0, ex_funct},  {26'd0, m_funct});
            check("m_wr_en",    {31'd0, ex_wr_en},  {31'd0, m_wr});
            check("m_is_load",  {31'd0, ex_is_load}, {31'd0, m_ld});
            if (m_valid && m_wr)
                check("m_dest", {27'd0, ex_dest}, {27'd0, m_dest});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        if_valid    = v;
        if_instr    = ins;
        if_pc       = pc;
        rf_rd_dataA = a;
        rf_rd_dataB = b;
    endtask

    task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wb_wr_en   = en;
        wb_wr_addr = addr;
        wb_wr_data = data;
    endtask

    task automatic ready_now(input string name, input logic exp);
        #1;
        check(name, {31'd0, if_ready}, {31'd0, exp});
    endtask

    logic [5:0] op_tab [16];

    // ---------------- stimulus ----------------
    initial begin
        op_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                   6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        nrst     = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        drive(1'b1, 32'h2023FFFC, 32'h0000_0100, 32'd10, 32'd0);

        // Reset holds with if_valid high.
        cyc();
        cyc();
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_pc",    ex_pc,  32'd0);
        check("rst_opA",   ex_opA, 32'd0);
        check("rst_imm",   ex_imm, 32'd0);
        check("rst_dest",  {27'd0, ex_dest}, 32'd0);
        check("rst_wr",    {31'd0, ex_wr_en}, 32'd0);

        // addi $3,$1,-4 with rf A = 10.
        nrst = 1'b1;
        ready_now("addi_ready", 1'b1);
        cyc();
        check("addi_valid", {31'd0, ex_valid}, 32'd1);
        check("addi_opA",   ex_opA, 32'd10);
        check("addi_imm",   ex_imm, 32'hFFFF_FFFC);
        check("addi_dest",  {27'd0, ex_dest}, 32'd3);
        check("addi_wr",    {31'd0, ex_wr_en}, 32'd1);

        // ori $2,$1,0x8000 zero-extends.
        drive(1'b1, 32'h3422_8000, 32'h0000_0104, 32'd0, 32'd0);
        cyc();
        check("ori_imm", ex_imm, 32'h0000_8000);

        // add $5,$2,$2 with write-back of $2 this edge, rf stale.
        drive(1'b1, 32'h0042_2820, 32'h0000_0108, 32'd0, 32'd0);
        wb(1'b1, 5'd2, 32'h0000_1234);
        cyc();
        check("byp_opA",  ex_opA, 32'h0000_1234);
        check("byp_opB",  ex_opB, 32'h0000_1234);
        check("byp_dest", {27'd0, ex_dest}, 32'd5);

        // Same add, write-back to $0: operands come from the rf.
        drive(1'b1, 32'h0042_2820, 32'h0000_010C, 32'h11, 32'h22);
        wb(1'b1, 5'd0, 32'h0000_1234);
        cyc();
        check("wb0_opA", ex_opA, 32'h11);
        check("wb0_opB", ex_opB, 32'h22);

        // add $5,$0,$2: rs = 0 gives operand 0 despite rf data.
        drive(1'b1, 32'h0002_2820, 32'h0000_0110, 32'h99, 32'h22);
        wb(1'b1, 5'd0, 32'h5555);
        cyc();
        check("rs0_opA", ex_opA, 32'd0);
        check("rs0_opB", ex_opB, 32'h22);
        wb(1'b0, 5'd0, 32'd0);

        // lw $4,0($1) then dependent add $6,$4,$7.
        drive(1'b1, 32'h8C24_0000, 32'h0000_0114, 32'h40, 32'd0);
        cyc();
        check("lw_load", {31'd0, ex_is_load}, 32'd1);
        drive(1'b1, 32'h0087_3020, 32'h0000_0118, 32'h4, 32'h7);
        ready_now("lu_stall", 1'b0);
        cyc();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        ready_now("lu_release", 1'b1);
        cyc();
        check("lu_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_pc",    ex_pc, 32'h0000_0118);

        // lw then independent add $6,$8,$7: no stall.
        drive(1'b1, 32'h8C24_0000, 32'h0000_011C, 32'h40, 32'd0);
        cyc();
        drive(1'b1, 32'h0107_3020, 32'h0000_0120, 32'h8, 32'h7);
        ready_now("nodep_ready", 1'b1);
        cyc();
        check("nodep_pc", ex_pc, 32'h0000_0120);

        // Backpressure for three cycles holds ID/EX.
        ex_ready = 1'b0;
        drive(1'b1, 32'h2023_0001, 32'h0000_0200, 32'd1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            ready_now("bp_ready", 1'b0);
            cyc();
            check("bp_valid", {31'd0, ex_valid}, 32'd1);
            check("bp_pc",    ex_pc, 32'h0000_0120);
        end
        flush = 1'b1;
        cyc();
        check("bp_flush", {31'd0, ex_valid}, 32'd0);

        // Flush with if_valid: not accepted.
        ex_ready = 1'b1;
        ready_now("fl_ready", 1'b0);
        cyc();
        check("fl_valid", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0;
        cyc();
        check("after_fl_pc", ex_pc, 32'h0000_0200);

        // Randomized traffic; small register range makes hazards frequent.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            logic [5:0]  fn;
            fn  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
            ins = {op_tab[$urandom_range(0, 15)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)), fn};
            if ($urandom_range(0, 1) == 0)
                ins[15:0] = 16'($urandom);
            drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom);
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            flush    = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            nrst     = ($urandom_range(0, 63) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
